// File: rtl/mips_instr_encoder.sv
// Encodes one symbolic MIPS instruction per handshake and writes it into the
// instruction memory at the next sequential address, with IM backpressure.
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [3:0]  ReqType,
  input  logic [4:0]  ReqRs,
  input  logic [4:0]  ReqRt,
  input  logic [4:0]  ReqRd,
  input  logic [15:0] ReqImm,
  input  logic [31:0] ReqTarget,
  output logic        ImWe,
  output logic [31:0] ImAddr,
  output logic [31:0] ImData,
  input  logic        ImBusy,
  output logic [10:0] WordCount,
  output logic        Full,
  output logic        Error,
  output logic [1:0]  ErrorCode
);

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  typedef enum logic [3:0] {
    T_NOP = 4'd0, T_ADDU = 4'd1, T_SUBU = 4'd2, T_ORI = 4'd3, T_LW  = 4'd4,
    T_SW  = 4'd5, T_BEQ  = 4'd6, T_LUI  = 4'd7, T_JAL = 4'd8, T_JR  = 4'd9
  } req_type_t;

  localparam logic [1:0] E_NONE = 2'd0, E_TYPE = 2'd1, E_BEQ = 2'd2, E_JAL = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] wrptr_q, wrptr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [1:0]  ecode_q, ecode_d;

  logic [31:0] pc4, off, enc_word;
  logic [1:0]  enc_code;
  logic        accept, wr_done;

  // PC-relative targets are resolved against the address this word will occupy
  always_comb begin
    pc4      = wrptr_q + 32'd4;
    off      = ReqTarget - pc4;
    enc_word = 32'h0;
    enc_code = E_NONE;
    case (ReqType)
      T_NOP:  enc_word = 32'h0;
      T_ADDU: enc_word = {6'h00, ReqRs, ReqRt, ReqRd, 5'h00, 6'h21};
      T_SUBU: enc_word = {6'h00, ReqRs, ReqRt, ReqRd, 5'h00, 6'h23};
      T_JR:   enc_word = {6'h00, ReqRs, 15'h0000, 6'h08};
      T_ORI:  enc_word = {6'h0d, ReqRs, ReqRt, ReqImm};
      T_LW:   enc_word = {6'h23, ReqRs, ReqRt, ReqImm};
      T_SW:   enc_word = {6'h2b, ReqRs, ReqRt, ReqImm};
      T_LUI:  enc_word = {6'h0f, 5'h00, ReqRt, ReqImm};
      T_BEQ: begin
        enc_word = {6'h04, ReqRs, ReqRt, off[17:2]};
        // off must be word aligned and fit in a signed 18-bit byte offset
        if ((off[1:0] != 2'b00) || (off[31:17] != {15{off[17]}}))
          enc_code = E_BEQ;
      end
      T_JAL: begin
        enc_word = {6'h03, ReqTarget[27:2]};
        if ((ReqTarget[31:28] != pc4[31:28]) || (ReqTarget[1:0] != 2'b00))
          enc_code = E_JAL;
      end
      default: enc_code = E_TYPE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (enc_code == E_NONE)) state_d = S_WRITE;
      S_WRITE: if (!ImBusy) state_d = ((wcnt_q + 11'd1) == DEPTH_W) ? S_FULL : S_IDLE;
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Full     = (wcnt_q == DEPTH_W);
    ReqReady = (state_q == S_IDLE) && !Full;
    ImWe     = (state_q == S_WRITE);
    accept   = ReqValid && ReqReady;
    wr_done  = ImWe && !ImBusy;
  end

  always_comb begin
    wrptr_d = wrptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    ecode_d = ecode_q;
    if (accept) begin
      if (enc_code == E_NONE) begin
        addr_d = wrptr_q;
        data_d = enc_word;
      end else begin
        err_d = 1'b1;
        if (ecode_q == E_NONE) ecode_d = enc_code;
      end
    end
    if (wr_done) begin
      wrptr_d = wrptr_q + 32'd4;
      wcnt_d  = wcnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr_q <= BASE_ADDR;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'h0;
      wcnt_q  <= 11'd0;
      err_q   <= 1'b0;
      ecode_q <= E_NONE;
    end else begin
      wrptr_q <= wrptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
    end
  end

  assign ImAddr    = addr_q;
  assign ImData    = data_q;
  assign WordCount = wcnt_q;
  assign Error     = err_q;
  assign ErrorCode = ecode_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed cases plus random requests against an
// arithmetic reference encoder; a second DEPTH=2 instance covers Full and reset.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, vld, busy;
  logic [3:0]  typ;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] tgt;
  logic        rdy, we, full, err;
  logic [31:0] addr, data;
  logic [10:0] wc;
  logic [1:0]  ecode;

  logic        s_rst, s_vld, s_busy;
  logic [3:0]  s_typ;
  logic        s_rdy, s_we, s_full, s_err;
  logic [31:0] s_addr, s_data;
  logic [10:0] s_wc;
  logic [1:0]  s_ecode;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_err;
  logic [1:0]  m_code;

  always #5 clk = ~clk;

  mips_instr_encoder u_dut (
    .clk(clk), .reset(rst), .ReqValid(vld), .ReqReady(rdy), .ReqType(typ),
    .ReqRs(rs), .ReqRt(rt), .ReqRd(rd), .ReqImm(imm), .ReqTarget(tgt),
    .ImWe(we), .ImAddr(addr), .ImData(data), .ImBusy(busy),
    .WordCount(wc), .Full(full), .Error(err), .ErrorCode(ecode)
  );

  mips_instr_encoder #(.BASE_ADDR(32'h0000_3000), .DEPTH(2)) u_small (
    .clk(clk), .reset(s_rst), .ReqValid(s_vld), .ReqReady(s_rdy), .ReqType(s_typ),
    .ReqRs(rs), .ReqRt(rt), .ReqRd(rd), .ReqImm(imm), .ReqTarget(tgt),
    .ImWe(s_we), .ImAddr(s_addr), .ImData(s_data), .ImBusy(s_busy),
    .WordCount(s_wc), .Full(s_full), .Error(s_err), .ErrorCode(s_ecode)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoder: returns {error_code, word} from plain field arithmetic
  function automatic logic [33:0] ref_enc(input logic [3:0] t, input logic [4:0] a, b, c,
                                          input logic [15:0] im, input logic [31:0] tg,
                                          input logic [31:0] pc);
    logic [31:0] w, pc4;
    logic [1:0]  code;
    longint      o;
    w = 0; code = 0;
    pc4 = pc + 32'd4;
    o = longint'($signed(tg - pc4));
    case (t)
      4'd0: w = 0;
      4'd1: w = a * 32'd2097152 + b * 32'd65536 + c * 32'd2048 + 32'd33;
      4'd2: w = a * 32'd2097152 + b * 32'd65536 + c * 32'd2048 + 32'd35;
      4'd3: w = (32'd13 << 26) + a * 32'd2097152 + b * 32'd65536 + im;
      4'd4: w = (32'd35 << 26) + a * 32'd2097152 + b * 32'd65536 + im;
      4'd5: w = (32'd43 << 26) + a * 32'd2097152 + b * 32'd65536 + im;
      4'd6: begin
        if ((o % 4 != 0) || (o < -131072) || (o > 131071)) code = 2;
        w = (32'd4 << 26) + a * 32'd2097152 + b * 32'd65536 + 32'((o / 4) & 64'hFFFF);
      end
      4'd7: w = (32'd15 << 26) + b * 32'd65536 + im;
      4'd8: begin
        if ((tg / 32'h1000_0000 != pc4 / 32'h1000_0000) || (tg % 4 != 0)) code = 3;
        w = (32'd3 << 26) + (tg % 32'h1000_0000) / 4;
      end
      4'd9: w = a * 32'd2097152 + 32'd8;
      default: code = 1;
    endcase
    return {code, w};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_pc = 32'h3000; m_cnt = 0; m_err = 0; m_code = 0;
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 32'h3000);
    chk("rst_data", data, 0);
    chk("rst_wc", wc, 0);
    chk("rst_err", {err, ecode}, 0);
    chk("rst_rdy", rdy, 1);
  endtask

  task automatic send(input logic [3:0] t, input logic [4:0] a, b, c, input logic [15:0] im,
                      input logic [31:0] tg, input int nbusy, output logic [31:0] word);
    logic [33:0] r;
    r = ref_enc(t, a, b, c, im, tg, m_pc);
    word = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ready", rdy, 1);
    vld = 1; typ = t; rs = a; rt = b; rd = c; imm = im; tgt = tg;
    @(posedge clk); #1;
    vld = 0;
    if (r[33:32] == 0) begin
      word = data;
      chk("we", we, 1);
      chk("addr", addr, m_pc);
      chk("data", data, r[31:0]);
      busy = (nbusy > 0);
      for (int i = 0; i < nbusy; i++) begin
        @(posedge clk); #1;
        chk("stall_we", we, 1);
        chk("stall_addr", addr, m_pc);
        chk("stall_data", data, r[31:0]);
        chk("stall_rdy", rdy, 0);
        chk("stall_wc", wc, m_cnt);
      end
      busy = 0;
      @(posedge clk); #1;
      m_pc += 4; m_cnt++;
      chk("done_we", we, 0);
      chk("done_wc", wc, m_cnt);
      chk("done_rdy", rdy, 1);
    end else begin
      m_err = 1;
      if (m_code == 0) m_code = r[33:32];
      chk("rej_we", we, 0);
      chk("rej_wc", wc, m_cnt);
      chk("rej_rdy", rdy, 1);
    end
    chk("err", err, m_err);
    chk("ecode", ecode, m_code);
  endtask

  initial begin
    logic [31:0] w, pc4, rt32;
    logic [3:0]  t;
    rst = 1; vld = 0; busy = 0; typ = 0; rs = 0; rt = 0; rd = 0; imm = 0; tgt = 0;
    s_rst = 1; s_vld = 0; s_busy = 0; s_typ = 0;
    repeat (2) @(posedge clk);
    s_rst = 0;

    do_reset();
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, w);
    chk("addu_word", w, 32'h0022_1821);

    do_reset();
    send(4'd3, 5'd0, 5'd1, 5'd0, 16'h1234, 32'h0, 0, w);
    chk("ori_word", w, 32'h3401_1234);
    send(4'd7, 5'd0, 5'd5, 5'd0, 16'hABCD, 32'h0, 1, w);
    chk("lui_word", w, 32'h3C05_ABCD);

    do_reset();
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0, 32'h3010, 3, w);
    chk("beq_word", w, 32'h1022_0003);

    do_reset();
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0, 32'h3000, 0, w);
    chk("beq_back", w, 32'h1022_FFFF);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0, 32'h3002, 0, w);
    chk("beq_unal_code", ecode, 2);
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 32'h3020, 0, w);
    chk("jal_word", w, 32'h0C00_0C08);

    do_reset();
    send(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, w);
    chk("illegal_code", ecode, 1);
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 0, w);
    chk("jal_region_code", ecode, 1);

    do_reset();
    for (int n = 0; n < 200; n++) begin
      t = 4'($urandom_range(0, 11));
      pc4 = m_pc + 4;
      rt32 = $urandom;
      if (t == 4'd6)
        tgt = $urandom_range(0, 1) ? pc4 + ($urandom & 32'h0003_FFFF) - 32'h0002_0000 : rt32;
      else if (t == 4'd8)
        tgt = $urandom_range(0, 1) ? {pc4[31:28], rt32[27:2], 2'b00} : rt32;
      else
        tgt = rt32;
      send(t, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), tgt,
           $urandom_range(0, 2), w);
    end

    // DEPTH=2 instance: reset abandons a stalled write, then fill to Full
    @(negedge clk);
    s_vld = 1; s_typ = 4'd1; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    @(posedge clk); #1;
    s_vld = 0; s_busy = 1;
    chk("s_we", s_we, 1);
    chk("s_data", s_data, 32'h0022_1821);
    @(negedge clk);
    s_rst = 1;
    @(posedge clk); #1;
    s_rst = 0; s_busy = 0;
    chk("s_rst_we", s_we, 0);
    chk("s_rst_wc", s_wc, 0);
    chk("s_rst_addr", s_addr, 32'h3000);
    chk("s_rst_data", s_data, 0);
    chk("s_rst_rdy", s_rdy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("s_rdy", s_rdy, 1);
      s_vld = 1; s_typ = 4'd0;
      @(posedge clk); #1;
      s_vld = 0;
      chk("s_addr", s_addr, 32'h3000 + 4 * k);
      chk("s_nop", s_data, 0);
      @(posedge clk); #1;
      chk("s_wc", s_wc, k + 1);
    end
    chk("s_full", s_full, 1);
    chk("s_full_rdy", s_rdy, 0);
    @(negedge clk);
    s_vld = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("s_full_we", s_we, 0);
      chk("s_full_wc", s_wc, 2);
    end
    s_vld = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
